// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes, frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Mode 3 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Cycles of line activity for one frame; a divider of 0 counts as 1.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned data_bits,
                                               input logic [1:0]  mode,
                                               input logic        two_stop);
    int unsigned n;
    int unsigned bits;
    n    = (clks_per_bit == 32'd0) ? 32'd1 : clks_per_bit;
    bits = 32'd1 + data_bits + (parity_enabled(mode) ? 32'd1 : 32'd0)
         + (two_stop ? 32'd2 : 32'd1);
    return n * bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle tick at every bit boundary.
module uart_bit_timer #(
  parameter int unsigned DIV_W = 18
) (
  input  logic             internal_clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] reload_c;

  assign reload_c = (div == '0) ? '0 : div - DIV_W'(1);

  // Tick on the last cycle of a bit; a fresh load never ticks.
  assign tick = !start && (cnt_q == '0);

  // Count down, reloading on start or on reaching zero.
  always_ff @(posedge internal_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start || (cnt_q == '0)) begin
      cnt_q <= reload_c;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: DATA_BITS data, optional parity, 1/2 stop bits,
// valid/ready byte handshake with back-to-back framing.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 18
) (
  input  logic                 internal_clock,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     CLK_PERS_BIT,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 Tx_Serial,
  output logic                 Tx_Active,
  output logic                 Tx_Done
);

  localparam int unsigned     IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic                 accept_c;
  logic                 tick;
  logic [DIV_W-1:0]     n_live_c, n_q, div_c;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 par_en_q, par_bit_q, two_stop_q, stop_cnt_q;
  logic                 serial_d, active_d, done_d, ready_d;

  assign accept_c = tx_valid && tx_ready;
  assign n_live_c = (CLK_PERS_BIT == '0) ? DIV_W'(1) : CLK_PERS_BIT;
  // The divider being latched is used for the very first bit of the frame.
  assign div_c    = accept_c ? n_live_c : n_q;

  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .internal_clock (internal_clock),
    .rst_n          (rst_n),
    .start          (accept_c),
    .div            (div_c),
    .tick           (tick)
  );

  // State register.
  always_ff @(posedge internal_clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_START;
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA:   if (tick && (bit_idx_q == LAST_IDX)) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick && (!two_stop_q || stop_cnt_q)) state_d = ST_DONE;
      ST_DONE:   state_d = accept_c ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: latch settings on accept, shift data and count stop bits on ticks.
  always_ff @(posedge internal_clock or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else if (accept_c) begin
      n_q        <= n_live_c;
      shift_q    <= tx_data;
      bit_idx_q  <= '0;
      par_en_q   <= parity_enabled(parity_mode);
      par_bit_q  <= (^tx_data) ^ (parity_mode == PAR_ODD);
      two_stop_q <= two_stop;
      stop_cnt_q <= 1'b0;
    end else if (tick) begin
      if (state_q == ST_DATA) begin
        shift_q <= shift_q >> 1;
        if (bit_idx_q != LAST_IDX) bit_idx_q <= bit_idx_q + IDX_W'(1);
      end
      if (state_q == ST_STOP) stop_cnt_q <= ~stop_cnt_q;
    end
  end

  // Output decode; line levels follow the state one cycle later through the output flops.
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_START:  begin serial_d = 1'b0;       active_d = 1'b1; end
      ST_DATA:   begin serial_d = shift_q[0]; active_d = 1'b1; end
      ST_PARITY: begin serial_d = par_bit_q;  active_d = 1'b1; end
      ST_STOP:   active_d = 1'b1;
      ST_DONE:   done_d = 1'b1;
      default:   ;
    endcase
    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge internal_clock or negedge rst_n) begin
    if (!rst_n) begin
      Tx_Serial <= 1'b1;
      Tx_Active <= 1'b0;
      Tx_Done   <= 1'b0;
      tx_ready  <= 1'b1;
    end else begin
      Tx_Serial <= serial_d;
      Tx_Active <= active_d;
      Tx_Done   <= done_d;
      tx_ready  <= ready_d;
    end
  end

endmodule
